aes_inv_cipher: RTL
===================

// Module: aes_inv_cipher
// PURPOSE
//  Iterative AES-128 inverse cipher (decryption): counterpart to the AES_top encryption core,
//  with the same port style. Accepts a 128-bit ciphertext and the 128-bit cipher key.
//  Expands the key schedule on-chip, then runs one inverse round per clock.
//  Sits beside AES_top so that encrypt->decrypt round-trips close in one subsystem.
// PARAMETERS
//  DATA_W      128  block/key width; only 128 supported
//  NUM_ROUNDS  10   AES-128 round count; only 10 supported
// PORTS
//  AES_clk             in   1    single clock, rising edge
//  AES_rst_n           in   1    asynchronous, active-low reset
//  AES_en              in   1    start request; rising edge (0->1 across two samples) starts an op
//  AES_data_in         in   128  ciphertext; [127:120]=FIPS byte 0, column-major state
//  AES_key_in          in   128  cipher key (round key 0), same byte order
//  AES_data_out        out  128  plaintext; holds last result until next completion
//  AES_data_out_valid  out  1    one-cycle pulse when AES_data_out updates
//  AES_busy            out  1    high from the edge after the start sample until valid pulses
// BEHAVIOUR
//  Reset: state=IDLE, AES_data_out=0, AES_data_out_valid=0, AES_busy=0, en_q=0, round keys=0.
//  Start: edge E0 samples AES_en=1 with en_q=0 while in IDLE -> latch data and key, go to KEYEXP.
//    The level of AES_en is otherwise ignored. Holding AES_en high never re-triggers.
//    An AES_en edge while not IDLE is dropped, not queued.
//  KEYEXP: edges E1..E10 compute rk[1..10] (RotWord/SubWord/Rcon) into a 10x128 register file.
//    Uses 4 forward S-boxes.
//  ADDKEY: E11 state <= ct ^ rk[10].
//  ROUND: E12..E20, r=9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
//  FINAL: E21 AES_data_out <= InvSubBytes(InvShiftRows(state)) ^ rk[0].
//    AES_data_out_valid=1 for exactly that one cycle. AES_busy=0. Return to IDLE.
//  Latency: fixed 21 clocks from start sample to valid. Throughput: one block per 22 clocks at most.
//    A start edge can be sampled in the cycle after valid.
//  Counter: 4-bit round counter, loaded 1 at KEYEXP, 9 at ROUND; no wrap (states bound it).
//  GF(2^8) with poly 0x11B. InvMixColumns coefficients {0e,0b,0d,09}.
//  Reset mid-operation: immediate abort, all outputs to reset values, no valid pulse.
//  AES_data_in/AES_key_in changes after E0 have no effect on the op in flight.
// STRUCTURE
//  aes_pkg (shared with AES_top):
//    - state encoding IDLE/KEYEXP/ADDKEY/ROUND/FINAL
//    - RCON[1..10] constants
//    - functions xtime, gf_mul (x9/xb/xd/xe), inv_shift_rows, inv_mix_columns
//  Sub-module aes_inv_sbox (256-entry combinational LUT), 16 instances in the datapath.
//  Key expansion reuses the existing forward aes_sbox (4 instances).
// TESTING
//  1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//       -> out 00112233445566778899aabbccddeeff, valid on 21st edge after start.
//  2. FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32
//       -> out 3243f6a8885a308d313198a2e0370734.
//  3. Zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> out 0.
//     Hold AES_en high 50 cycles -> exactly one valid pulse.
//  4. Round-trip: AES_top encrypts 00000089_00000000_00000000_00000000 with key
//     aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc; feed its output here with the same key -> out equals
//     the original plaintext.
//  5. Second AES_en edge at E5 with new data -> ignored; result matches the first op.
//     AES_data_in changes after E0 are also ignored.
//  6. Assert AES_rst_n=0 at E8 for 1 cycle -> no valid, outputs 0.
//     The next start edge then decrypts C.1 correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, key-schedule round constants
// and the GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    ADDKEY,
    ROUND,
    FINAL
  } aes_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplies only by the InvMixColumns coefficients, built from doubling chains.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8, r;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    case (c)
      4'h9:    r = b8 ^ b;
      4'hb:    r = b8 ^ b2 ^ b;
      4'hd:    r = b8 ^ b4 ^ b;
      4'he:    r = b8 ^ b4 ^ b2;
      default: r = b;
    endcase
    return r;
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box as a 256-entry combinational lookup; entry 0 is the top byte.
module aes_inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign out_o = INV_SBOX_TBL[{~in_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box as a 256-entry combinational lookup; entry 0 is the top byte.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x occupies bits [2047-8x -: 8], i.e. top index {~x, 3'b111}.
  assign out_o = SBOX_TBL[{~in_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor: expands the key schedule into a register file,
// then applies one inverse round per clock; fixed 21-clock latency from start.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              AES_en,
  input  logic [DATA_W-1:0] AES_data_in,
  input  logic [DATA_W-1:0] AES_key_in,
  output logic [DATA_W-1:0] AES_data_out,
  output logic              AES_data_out_valid,
  output logic              AES_busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  aes_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              en_q;
  logic              start;
  logic [DATA_W-1:0] rk_q [0:NUM_ROUNDS];
  logic [DATA_W-1:0] blk_q, out_q;
  logic              valid_q;

  logic [DATA_W-1:0] key_prev, key_next;
  logic [31:0]       rot_word, sub_word, key_tmp, w0, w1, w2, w3;
  logic [DATA_W-1:0] isr, isb, inv_round;

  assign start = AES_en && !en_q && (state_q == IDLE);

  // State register
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // NOTE: en_q follows AES_en every cycle, so a level held through a whole op never reads as an edge.
      en_q    <= AES_en;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = KEYEXP;
        cnt_d   = 4'd1;
      end
      KEYEXP: begin
        if (cnt_q == LAST_RND) state_d = ADDKEY;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ADDKEY: begin
        state_d = ROUND;
        cnt_d   = LAST_RND - 4'd1;
      end
      ROUND: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINAL;
      end
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    AES_busy           = (state_q != IDLE);
    AES_data_out       = out_q;
    AES_data_out_valid = valid_q;
  end

  // Key schedule step: derives rk[cnt] from rk[cnt-1]
  assign key_prev         = rk_q[cnt_q - 4'd1];
  assign {w0, w1, w2, w3} = key_prev;
  assign rot_word         = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.in_i(rot_word[31-8*i -: 8]), .out_o(sub_word[31-8*i -: 8]));
  end

  assign key_tmp  = sub_word ^ {rcon(cnt_q), 24'h0};
  assign key_next = {w0 ^ key_tmp,
                     w1 ^ w0 ^ key_tmp,
                     w2 ^ w1 ^ w0 ^ key_tmp,
                     w3 ^ w2 ^ w1 ^ w0 ^ key_tmp};

  // Inverse round body; the counter reaches 0 in FINAL so rk[cnt] is rk[0] there.
  assign isr = inv_shift_rows(blk_q);

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (.in_i(isr[127-8*i -: 8]), .out_o(isb[127-8*i -: 8]));
  end

  assign inv_round = isb ^ rk_q[cnt_q];

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      blk_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      // NOTE: the round-key file is cleared too, so an aborted op leaves no key material behind.
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          blk_q   <= AES_data_in;
          rk_q[0] <= AES_key_in;
        end
        KEYEXP: rk_q[cnt_q] <= key_next;
        ADDKEY: blk_q <= blk_q ^ rk_q[NUM_ROUNDS];
        ROUND:  blk_q <= inv_mix_columns(inv_round);
        FINAL: begin
          out_q   <= inv_round;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
